// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;
  localparam logic [4:0] EXC_DEFAULT = 5'd0;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC/PRId, interrupt and exception entry, eret.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2022
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  input  logic        CP0WE,
  input  logic [31:0] VPC,
  input  logic        isIDS,
  input  logic [4:0]  excCode,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        requestInt
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req    = sr_ie & ~sr_exl & (|(HWInt & sr_im));
  assign exc_req    = ~sr_exl & (excCode != EXC_DEFAULT);
  assign requestInt = int_req | exc_req;

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
  assign EPCOut    = epc;

  always_comb begin
    CP0Out = 32'b0;
    case (CP0Addr)
      REG_SR:    CP0Out = sr_val;
      REG_CAUSE: CP0Out = cause_val;
      REG_EPC:   CP0Out = epc;
      REG_PRID:  CP0Out = PRID;
      default:   CP0Out = 32'b0;
    endcase
  end

  // Exception entry wins over mtc0; eret's EXL clear wins over an mtc0 to SR.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (requestInt) begin
        sr_exl    <= 1'b1;
        cause_bd  <= isIDS;
        cause_exc <= int_req ? EXC_INT : excCode;
        epc       <= isIDS ? (VPC - 32'd4) : VPC;
      end else begin
        if (CP0WE && (CP0Addr == REG_SR)) begin
          sr_im  <= CP0In[SR_IM_HI:SR_IM_LO];
          sr_exl <= CP0In[SR_EXL];
          sr_ie  <= CP0In[SR_IE];
        end
        if (CP0WE && (CP0Addr == REG_EPC)) begin
          epc <= CP0In;
        end
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: stimulus queues expected outputs, a negedge monitor compares them.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic        CP0WE;
  logic [31:0] VPC;
  logic        isIDS;
  logic [4:0]  excCode;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        requestInt;

  cp0 #(.PRID(32'h0000_2022)) dut (
    .clk(clk), .reset(reset), .CP0Addr(CP0Addr), .CP0In(CP0In), .CP0WE(CP0WE),
    .VPC(VPC), .isIDS(isIDS), .excCode(excCode), .EXLClr(EXLClr), .HWInt(HWInt),
    .CP0Out(CP0Out), .EPCOut(EPCOut), .requestInt(requestInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0: CP0Out, 1: EPCOut, 2: requestInt
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: at each negedge, compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = CP0Out;
        1:       act = EPCOut;
        default: act = {31'b0, requestInt};
      endcase
      checks++;
      if (act !== e.value) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.value);
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] value);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    CP0WE   = 1'b0;
    EXLClr  = 1'b0;
    excCode = 5'd0;
    isIDS   = 1'b0;
    CP0Addr = 5'd0;
    CP0In   = 32'h0;
  endtask

  task automatic rd(input logic [4:0] addr, input string name, input logic [31:0] value);
    CP0Addr = addr;
    expect_val(name, 0, value);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; CP0Addr = 5'd0; CP0In = 32'h0; CP0WE = 1'b0; VPC = 32'h0;
    isIDS = 1'b0; excCode = 5'd0; EXLClr = 1'b0; HWInt = 6'd0;
    step();
    expect_val("req_in_reset", 2, 32'd0);
    step();
    reset = 1'b0;

    // Reset state
    rd(5'd12, "sr_reset", 32'h0);
    rd(5'd13, "cause_reset", 32'h0);
    rd(5'd14, "epc_reset", 32'h0);
    rd(5'd15, "prid", 32'h0000_2022);
    rd(5'd3, "unimpl_addr", 32'h0);

    // Enable IM[0]/IE; read during the write cycle still shows the old value
    CP0WE = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0401;
    expect_val("sr_no_bypass", 0, 32'h0);
    step();
    rd(5'd12, "sr_written", 32'h0000_0401);

    // Hardware interrupt
    HWInt = 6'b000001; VPC = 32'h0000_3000;
    expect_val("int_req", 2, 32'd1);
    step();
    expect_val("req_blocked_exl", 2, 32'd0);
    rd(5'd13, "cause_int", 32'h0000_0400);
    rd(5'd12, "sr_exl_set", 32'h0000_0403);
    expect_val("epc_int", 1, 32'h0000_3000);
    HWInt = 6'd0; EXLClr = 1'b1;
    step();
    rd(5'd12, "sr_after_eret", 32'h0000_0401);
    rd(5'd13, "cause_ip_clr", 32'h0);

    // Overflow in delay slot
    excCode = 5'd12; isIDS = 1'b1; VPC = 32'h0000_3010;
    expect_val("ov_req", 2, 32'd1);
    step();
    rd(5'd14, "epc_ds", 32'h0000_300C);
    rd(5'd13, "cause_ov_bd", 32'h8000_0030);
    excCode = 5'd4;
    expect_val("adel_blocked", 2, 32'd0);
    step();
    rd(5'd13, "cause_unchanged", 32'h8000_0030);
    // eret beats an mtc0 that sets EXL
    EXLClr = 1'b1; CP0WE = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0403;
    step();
    rd(5'd12, "eret_over_mtc0", 32'h0000_0401);

    // Interrupt priority over RI
    HWInt = 6'b000001; excCode = 5'd10; VPC = 32'h0000_3020;
    expect_val("int_ri_req", 2, 32'd1);
    step();
    HWInt = 6'd0;
    rd(5'd13, "int_priority", 32'h0000_0400);
    expect_val("epc_int_ri", 1, 32'h0000_3020);
    EXLClr = 1'b1;
    step();

    // Cause and PRId are not writable; SR write is masked
    CP0WE = 1'b1; CP0Addr = 5'd13; CP0In = 32'hFFFF_FFFF;
    step();
    rd(5'd13, "cause_ro", 32'h0);
    CP0WE = 1'b1; CP0Addr = 5'd15; CP0In = 32'h1234_5678;
    step();
    rd(5'd15, "prid_ro", 32'h0000_2022);
    CP0WE = 1'b1; CP0Addr = 5'd12; CP0In = 32'hFFFF_FFFE;
    step();
    rd(5'd12, "sr_mask", 32'h0000_FC02);
    CP0WE = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_0401;
    step();

    // mtc0 EPC suppressed by concurrent exception
    CP0WE = 1'b1; CP0Addr = 5'd14; CP0In = 32'h0000_3400; excCode = 5'd5; VPC = 32'h0000_3100;
    expect_val("ades_req", 2, 32'd1);
    step();
    expect_val("epc_suppressed", 1, 32'h0000_3100);
    rd(5'd13, "cause_ades", 32'h0000_0014);

    // Reset mid-handler
    reset = 1'b1; HWInt = 6'b000001;
    step();
    reset = 1'b0;
    expect_val("req_after_reset", 2, 32'd0);
    expect_val("epc_after_reset", 1, 32'h0);
    rd(5'd12, "sr_after_reset", 32'h0);
    HWInt = 6'd0;
    rd(5'd13, "cause_after_reset", 32'h0000_0400);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
